// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single write port of the register file between NumReq writeback
//   requesters using round-robin arbitration. The granted request is staged in
//   a register that drives the register file write port one cycle after the
//   handshake. The staged write is forwarded to both read ports so that a
//   reader never sees stale data while the write is in flight.
//
//   Optional feature macro: ZERO_REG_PROTECT_EN
//     defined   : address 0 is hard-wired to zero. Requests to it handshake but
//                 are dropped, and reads of it return 0.
//     undefined : address 0 is an ordinary register.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   req_valid  in   [NumReq]              per-requester write request
//   req_addr   in   [NumReq*IndexWidth]   packed destination addresses
//   req_data   in   [NumReq*DataWidth]    packed write data
//   req_ready  out  [NumReq]              one-hot grant (combinational)
//   wr_en      out                        register file write enable
//   wr_addr    out  [IndexWidth]          register file write address
//   wr_data    out  [DataWidth]           register file write data
//   rd_addr1   in   [IndexWidth]          read address 1
//   rd_addr2   in   [IndexWidth]          read address 2
//   rf_rdata1  in   [DataWidth]           register file read data 1
//   rf_rdata2  in   [DataWidth]           register file read data 2
//   rd_data1   out  [DataWidth]           forwarded read data 1
//   rd_data2   out  [DataWidth]           forwarded read data 2
//   wr_count   out  [16]                  committed write count, saturating
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DataWidth  = 64,
  parameter int NumRegs    = 32,
  parameter int IndexWidth = $clog2(NumRegs),
  parameter int NumReq     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NumReq-1:0]            req_valid,
  input  logic [NumReq*IndexWidth-1:0] req_addr,
  input  logic [NumReq*DataWidth-1:0]  req_data,
  output logic [NumReq-1:0]            req_ready,
  output logic                         wr_en,
  output logic [IndexWidth-1:0]        wr_addr,
  output logic [DataWidth-1:0]         wr_data,
  input  logic [IndexWidth-1:0]        rd_addr1,
  input  logic [IndexWidth-1:0]        rd_addr2,
  input  logic [DataWidth-1:0]         rf_rdata1,
  input  logic [DataWidth-1:0]         rf_rdata2,
  output logic [DataWidth-1:0]         rd_data1,
  output logic [DataWidth-1:0]         rd_data2,
  output logic [15:0]                  wr_count
);

  localparam int PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrWidth-1:0]   rr_ptr_r;
  logic                  wr_en_r;
  logic [IndexWidth-1:0] wr_addr_r;
  logic [DataWidth-1:0]  wr_data_r;
  logic [15:0]           wr_count_r;

  logic                  found_s;
  logic [PtrWidth-1:0]   gnt_idx_s;
  logic [PtrWidth:0]     sum_s;
  logic [PtrWidth-1:0]   idx_s;
  logic [NumReq-1:0]     ready_s;
  logic [IndexWidth-1:0] sel_addr_s;
  logic [DataWidth-1:0]  sel_data_s;
  logic                  do_write_s;
  logic [PtrWidth-1:0]   next_ptr_s;
  logic [DataWidth-1:0]  rd_data1_s;
  logic [DataWidth-1:0]  rd_data2_s;

  // Round-robin search: first valid index at or after rr_ptr, wrapping.
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = '0;
    sum_s     = '0;
    idx_s     = '0;
    for (int k = 0; k < NumReq; k++) begin
      sum_s = {1'b0, rr_ptr_r} + (PtrWidth+1)'(k);
      if (sum_s >= (PtrWidth+1)'(NumReq)) begin
        sum_s = sum_s - (PtrWidth+1)'(NumReq);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PtrWidth-1:0];
      if (!found_s && req_valid[idx_s]) begin
        found_s   = 1'b1;
        gnt_idx_s = idx_s;
      end else begin
        found_s   = found_s;
      end
    end
  end

  // One-hot grant, suppressed during reset; selects the winner's payload.
  always_comb begin
    ready_s    = '0;
    sel_addr_s = req_addr[gnt_idx_s*IndexWidth +: IndexWidth];
    sel_data_s = req_data[gnt_idx_s*DataWidth +: DataWidth];
    if (found_s && !rst) begin
      ready_s[gnt_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Decide whether the grant turns into a register file write.
  always_comb begin
    do_write_s = 1'b0;
    if (found_s && !rst) begin
`ifdef ZERO_REG_PROTECT_EN
      // Register 0 is constant zero: the handshake completes but is dropped.
      do_write_s = (sel_addr_s != {IndexWidth{1'b0}});
`else
      do_write_s = 1'b1;
`endif
    end else begin
      do_write_s = 1'b0;
    end
  end

  // Pointer moves one past the granted requester, wrapping to 0.
  always_comb begin
    next_ptr_s = rr_ptr_r;
    if (gnt_idx_s == PtrWidth'(NumReq - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_idx_s + PtrWidth'(1);
    end
  end

  // Arbiter pointer, staged write and committed-write counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r   <= '0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      wr_count_r <= 16'h0000;
    end else begin
      if (found_s) begin
        rr_ptr_r <= next_ptr_s;
      end
      wr_en_r <= do_write_s;
      if (do_write_s) begin
        wr_addr_r <= sel_addr_s;
        wr_data_r <= sel_data_s;
      end
      // Counter saturates instead of wrapping.
      if (wr_en_r && (wr_count_r != 16'hFFFF)) begin
        wr_count_r <= wr_count_r + 16'h0001;
      end
    end
  end

  // Read-port forwarding of the in-flight write.
  always_comb begin
    rd_data1_s = rf_rdata1;
    rd_data2_s = rf_rdata2;
    if (wr_en_r && (rd_addr1 == wr_addr_r)) begin
      rd_data1_s = wr_data_r;
    end else begin
      rd_data1_s = rf_rdata1;
    end
    if (wr_en_r && (rd_addr2 == wr_addr_r)) begin
      rd_data2_s = wr_data_r;
    end else begin
      rd_data2_s = rf_rdata2;
    end
`ifdef ZERO_REG_PROTECT_EN
    if (rd_addr1 == {IndexWidth{1'b0}}) begin
      rd_data1_s = '0;
    end else begin
      rd_data1_s = rd_data1_s;
    end
    if (rd_addr2 == {IndexWidth{1'b0}}) begin
      rd_data2_s = '0;
    end else begin
      rd_data2_s = rd_data2_s;
    end
`endif
  end

  assign req_ready = ready_s;
  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign wr_count  = wr_count_r;
  assign rd_data1  = rd_data1_s;
  assign rd_data2  = rd_data2_s;

endmodule
